spi_command_master: RTL

SPI_COMMAND_MASTER -- requirements
Module: spi_command_master

---
 rtl/spi_command_master.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/spi_command_master.sv
// SPI mode-0 command master: sends a 32-bit word MSB first, captures the slave's word,
// and issues optional latch_data or control_trigger strobes to the sequencer.
`timescale 1ns/1ps
module spi_command_master #(
  parameter int CLK_DIV      = 4,
  parameter int PULSE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  input  logic        cmd_latch,
  output logic        cmd_ready,
  input  logic        trig_valid,
  output logic        trig_ready,
  output logic        sclk,
  output logic        mosi,
  output logic        ss_n,
  input  logic        miso,
  output logic        latch_data,
  output logic        control_trigger,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        busy
);

  // Handshake: a command or trigger is taken on a rising clock edge where valid and
  // ready are both high; ready is only offered in IDLE, and a command wins over a trigger.

  localparam int            DW         = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [7:0]    PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [6:0]    TOG_LAST   = 7'd63;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LATCH, TRIG} state_t;

  state_t        state, state_d;
  logic [DW-1:0] div_cnt, div_cnt_d;
  logic [6:0]    tog_cnt, tog_cnt_d;
  logic [7:0]    pulse_cnt, pulse_cnt_d;
  logic [30:0]   tx_sh, tx_sh_d;    // bits still to send; the current bit sits on mosi
  logic [31:0]   rx_sh, rx_sh_d;
  logic          latch_q, latch_q_d;
  logic          sclk_d, mosi_d, ss_n_d, latch_data_d, control_trigger_d, rx_valid_d;
  logic [31:0]   rx_data_d;
  logic          div_tick;

  assign div_tick   = (div_cnt == DIV_LAST);
  assign busy       = (state != IDLE);
  assign cmd_ready  = (state == IDLE) && !reset;
  assign trig_ready = (state == IDLE) && !reset && !cmd_valid;

  always_comb begin
    state_d           = state;
    div_cnt_d         = div_cnt;
    tog_cnt_d         = tog_cnt;
    pulse_cnt_d       = pulse_cnt;
    tx_sh_d           = tx_sh;
    rx_sh_d           = rx_sh;
    latch_q_d         = latch_q;
    sclk_d            = sclk;
    mosi_d            = mosi;
    ss_n_d            = ss_n;
    latch_data_d      = latch_data;
    control_trigger_d = control_trigger;
    rx_data_d         = rx_data;
    rx_valid_d        = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          tx_sh_d   = cmd_data[30:0];
          mosi_d    = cmd_data[31];
          latch_q_d = cmd_latch;
          ss_n_d    = 1'b0;
          div_cnt_d = '0;
          state_d   = SETUP;
        end else if (trig_valid) begin
          control_trigger_d = 1'b1;
          pulse_cnt_d       = '0;
          state_d           = TRIG;
        end
      end
      SETUP: begin
        if (div_tick) begin
          div_cnt_d = '0;
          tog_cnt_d = '0;
          state_d   = SHIFT;
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (div_tick) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk;
          tog_cnt_d = tog_cnt + 7'd1;
          if (!sclk) begin
            rx_sh_d = {rx_sh[30:0], miso};
          end else if (tog_cnt == TOG_LAST) begin
            state_d = HOLD;
          end else begin
            mosi_d  = tx_sh[30];
            tx_sh_d = {tx_sh[29:0], 1'b0};
          end
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (div_tick) begin
          div_cnt_d  = '0;
          ss_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sh;
          rx_valid_d = 1'b1;
          if (latch_q) begin
            latch_data_d = 1'b1;
            pulse_cnt_d  = '0;
            state_d      = LATCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (pulse_cnt == PULSE_LAST) begin
          latch_data_d = 1'b0;
          state_d      = IDLE;
        end else begin
          pulse_cnt_d = pulse_cnt + 8'd1;
        end
      end
      TRIG: begin
        if (pulse_cnt == PULSE_LAST) begin
          control_trigger_d = 1'b0;
          state_d           = IDLE;
        end else begin
          pulse_cnt_d = pulse_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      div_cnt         <= '0;
      tog_cnt         <= '0;
      pulse_cnt       <= '0;
      tx_sh           <= '0;
      rx_sh           <= '0;
      latch_q         <= 1'b0;
      sclk            <= 1'b0;
      mosi            <= 1'b0;
      ss_n            <= 1'b1;
      latch_data      <= 1'b0;
      control_trigger <= 1'b0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
    end else begin
      state           <= state_d;
      div_cnt         <= div_cnt_d;
      tog_cnt         <= tog_cnt_d;
      pulse_cnt       <= pulse_cnt_d;
      tx_sh           <= tx_sh_d;
      rx_sh           <= rx_sh_d;
      latch_q         <= latch_q_d;
      sclk            <= sclk_d;
      mosi            <= mosi_d;
      ss_n            <= ss_n_d;
      latch_data      <= latch_data_d;
      control_trigger <= control_trigger_d;
      rx_data         <= rx_data_d;
      rx_valid        <= rx_valid_d;
    end
  end

endmodule
